// File: rtl/arith_interval_coder_if.sv
// Bound-triple input and coded-bit output signals of the arithmetic interval coder.
// The master side is the model plus bit consumer; the slave side is the coder.
interface arith_interval_coder_if;
    logic [15:0] lower_bound_in;
    logic [15:0] upper_bound_in;
    logic [15:0] range_in;
    logic        valid_in;
    logic        flush_in;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        done_out;
    logic        busy_out;
    logic        overflow_out;
    logic        error_out;

    modport master (
        output lower_bound_in, upper_bound_in, range_in, valid_in, flush_in, bit_ready,
        input  bit_out, bit_valid, done_out, busy_out, overflow_out, error_out
    );

    modport slave (
        input  lower_bound_in, upper_bound_in, range_in, valid_in, flush_in, bit_ready,
        output bit_out, bit_valid, done_out, busy_out, overflow_out, error_out
    );
endinterface

// File: rtl/arith_interval_coder.sv
// Binary arithmetic-coding interval stage: FIFO of bound triples, serial divider,
// E1/E2/E3 renormalisation and a valid/ready bit serialiser with stream termination.
module arith_interval_coder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    arith_interval_coder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] HALF = 32'h8000_0000;
    localparam logic [31:0] QTR  = 32'h4000_0000;
    localparam logic [31:0] QTR3 = 32'hC000_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_DIVIDE, S_UPDATE, S_RENORM, S_EMIT, S_FLUSH, S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] lower;
        logic [15:0] upper;
        logic [15:0] total;
    } triple_t;

    triple_t     fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    state_t      state_q, state_d;
    logic [31:0] low_q, low_d;
    logic [31:0] high_q, high_d;
    logic [15:0] pending_q, pending_d;
    triple_t     cur_q, cur_d;
    logic [32:0] dq_q, dq_d;          // dividend shifted out, quotient shifted in
    logic [15:0] rem_q, rem_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic        emit_first_q, emit_first_d;
    logic        ret_done_q, ret_done_d;
    logic        flush_q, flush_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic        error_q, error_d;

    logic        fifo_empty, fifo_full, push, pop, head_illegal;
    triple_t     head, triple_in;
    logic [16:0] rem_sh;
    logic        rem_ge;
    logic [31:0] prod_hi, prod_lo, lo_adj, hi_adj;
    logic [15:0] pend_inc;

    assign triple_in = '{lower: bus.lower_bound_in, upper: bus.upper_bound_in, total: bus.range_in};
    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop          = (state_q == S_IDLE) && !fifo_empty;
    assign push         = bus.valid_in && (!fifo_full || pop);
    assign head_illegal = (head.total == 16'd0) || (head.lower >= head.upper) ||
                          (head.upper > head.total);

    assign rem_sh   = {rem_q, dq_q[32]};
    assign rem_ge   = (rem_sh >= {1'b0, cur_q.total});
    // Only the low 32 bits of step*bound matter: the interval result is truncated anyway.
    assign prod_hi  = dq_q[31:0] * {16'h0000, cur_q.upper};
    assign prod_lo  = dq_q[31:0] * {16'h0000, cur_q.lower};
    assign pend_inc = (pending_q == 16'hFFFF) ? pending_q : pending_q + 16'd1;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d      = state_q;
        low_d        = low_q;
        high_d       = high_q;
        pending_d    = pending_q;
        cur_d        = cur_q;
        dq_d         = dq_q;
        rem_d        = rem_q;
        div_cnt_d    = div_cnt_q;
        emit_first_d = emit_first_q;
        ret_done_d   = ret_done_q;
        flush_d      = flush_q | bus.flush_in;
        bit_out_d    = bit_out_q;
        bit_valid_d  = bit_valid_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q | (bus.valid_in && fifo_full && !pop);
        error_d      = error_q;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
        lo_adj       = low_q;
        hi_adj       = high_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cur_d = head;
                    if (head_illegal) begin
                        error_d = 1'b1;
                    end else begin
                        dq_d      = {1'b0, high_q} - {1'b0, low_q} + 33'd1;
                        rem_d     = 16'd0;
                        div_cnt_d = 6'd0;
                        state_d   = S_DIVIDE;
                    end
                end else if (flush_q) begin
                    state_d = S_FLUSH;
                end
            end

            S_DIVIDE: begin
                rem_d     = rem_ge ? rem_sh[15:0] - cur_q.total : rem_sh[15:0];
                dq_d      = {dq_q[31:0], rem_ge};
                div_cnt_d = div_cnt_q + 6'd1;
                if (div_cnt_q == 6'd32) state_d = S_UPDATE;
            end

            S_UPDATE: begin
                high_d  = low_q + prod_hi - 32'd1;
                low_d   = low_q + prod_lo;
                state_d = S_RENORM;
            end

            S_RENORM: begin
                if (high_q < HALF) begin
                    bit_out_d    = 1'b0;
                    bit_valid_d  = 1'b1;
                    emit_first_d = 1'b0;
                    ret_done_d   = 1'b0;
                    state_d      = S_EMIT;
                end else if (low_q >= HALF) begin
                    lo_adj       = low_q - HALF;
                    hi_adj       = high_q - HALF;
                    bit_out_d    = 1'b1;
                    bit_valid_d  = 1'b1;
                    emit_first_d = 1'b1;
                    ret_done_d   = 1'b0;
                    state_d      = S_EMIT;
                end else if (low_q >= QTR && high_q < QTR3) begin
                    lo_adj    = low_q - QTR;
                    hi_adj    = high_q - QTR;
                    pending_d = pend_inc;
                end else begin
                    state_d = S_IDLE;
                end
                if (state_d != S_IDLE) begin
                    low_d  = {lo_adj[30:0], 1'b0};
                    high_d = {hi_adj[30:0], 1'b1};
                end
            end

            S_EMIT: begin
                if (bus.bit_ready) begin
                    if (pending_q != 16'd0) begin
                        pending_d = pending_q - 16'd1;
                        bit_out_d = ~emit_first_q;
                    end else begin
                        bit_valid_d = 1'b0;
                        bit_out_d   = 1'b0;
                        done_d      = ret_done_q;
                        state_d     = ret_done_q ? S_DONE : S_RENORM;
                    end
                end
            end

            S_FLUSH: begin
                pending_d    = pend_inc;
                bit_out_d    = (low_q >= QTR);
                emit_first_d = (low_q >= QTR);
                bit_valid_d  = 1'b1;
                ret_done_d   = 1'b1;
                state_d      = S_EMIT;
            end

            S_DONE: begin
                low_d      = 32'h0000_0000;
                high_d     = 32'hFFFF_FFFF;
                pending_d  = 16'd0;
                flush_d    = 1'b0;
                overflow_d = 1'b0;
                error_d    = 1'b0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers take only non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            low_q        <= 32'h0000_0000;
            high_q       <= 32'hFFFF_FFFF;
            pending_q    <= 16'd0;
            cur_q        <= '0;
            dq_q         <= '0;
            rem_q        <= 16'd0;
            div_cnt_q    <= 6'd0;
            emit_first_q <= 1'b0;
            ret_done_q   <= 1'b0;
            flush_q      <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            high_q       <= high_d;
            pending_q    <= pending_d;
            cur_q        <= cur_d;
            dq_q         <= dq_d;
            rem_q        <= rem_d;
            div_cnt_q    <= div_cnt_d;
            emit_first_q <= emit_first_d;
            ret_done_q   <= ret_done_d;
            flush_q      <= flush_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= triple_in;
    end

    assign bus.bit_out      = bit_out_q;
    assign bus.bit_valid    = bit_valid_q;
    assign bus.done_out     = done_q;
    assign bus.overflow_out = overflow_q;
    assign bus.error_out    = error_q;
    assign bus.busy_out     = !fifo_empty || (state_q != S_IDLE) || flush_q;
endmodule

// File: tb/tb_arith_interval_coder.sv
// Self-checking bench for arith_interval_coder: vector table, golden adaptive-model
// stream, overflow, backpressure, reset and randomized streams against an arithmetic model.
module tb_arith_interval_coder;
    localparam int DEPTH = 16;
    localparam longint unsigned HALF = 64'h8000_0000;
    localparam longint unsigned QTR  = 64'h4000_0000;
    localparam longint unsigned QTR3 = 64'hC000_0000;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] up;
        logic [15:0] tot;
    } sym_t;
    typedef sym_t symq_t[$];
    typedef bit   bitq_t[$];

    typedef struct {
        logic [15:0] lo;
        logic [15:0] up;
        logic [15:0] tot;
        int          nbits;
        logic [7:0]  bits;   // bits[nbits-1] is emitted first
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arith_interval_coder_if ifc ();
    arith_interval_coder #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_valid_cyc = -1;
    int          done_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_bit = 1'b0;
    bitq_t       got_bits;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic-coding reference written directly from the interval rules.
    function automatic bitq_t model(input symq_t q);
        bitq_t b;
        longint unsigned lo = 0, hi = 64'hFFFF_FFFF, pend = 0, step;
        foreach (q[i]) begin
            longint unsigned l, u, t;
            l = q[i].lo; u = q[i].up; t = q[i].tot;
            if (t == 0 || l >= u || u > t) continue;
            step = (hi - lo + 1) / t;
            hi = lo + step * u - 1;
            lo = lo + step * l;
            forever begin
                if (hi < HALF) begin
                    b.push_back(1'b0); repeat (pend) b.push_back(1'b1); pend = 0;
                end else if (lo >= HALF) begin
                    b.push_back(1'b1); repeat (pend) b.push_back(1'b0); pend = 0;
                    lo -= HALF; hi -= HALF;
                end else if (lo >= QTR && hi < QTR3) begin
                    pend++; lo -= QTR; hi -= QTR;
                end else break;
                lo = 2 * lo;
                hi = 2 * hi + 1;
            end
        end
        pend++;
        if (lo < QTR) begin b.push_back(1'b0); repeat (pend) b.push_back(1'b1); end
        else          begin b.push_back(1'b1); repeat (pend) b.push_back(1'b0); end
        return b;
    endfunction

    // Adaptive two-symbol frequency model: counts start at 1 and grow per coded symbol.
    function automatic symq_t tree_model(input string s);
        symq_t q;
        int ca = 1, cb = 1;
        for (int i = 0; i < s.len(); i++) begin
            sym_t t;
            t.tot = 16'(ca + cb);
            if (s[i] == "a") begin t.lo = 16'd0; t.up = 16'(ca); ca++; end
            else begin t.lo = 16'(ca); t.up = 16'(ca + cb); cb++; end
            q.push_back(t);
        end
        return q;
    endfunction

    function automatic sym_t rand_sym();
        sym_t s;
        int t, l, u;
        t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 65535));
        l = int'($urandom_range(0, t - 1));
        u = int'($urandom_range(l + 1, t));
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0:       t = 0;
                1:       u = l;
                default: if (t < 65535) u = t + 1; else t = 0;
            endcase
        end
        s.lo = 16'(l); s.up = 16'(u); s.tot = 16'(t);
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bit consumer: drives bit_ready, records accepted bits, checks stall stability.
    always @(negedge clk) begin
        bit r;
        r = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        ifc.bit_ready = r;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", ifc.bit_valid, 1);
                check("stall_bit_held", ifc.bit_out, prev_bit);
            end
            if (ifc.bit_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ifc.bit_valid && r) got_bits.push_back(ifc.bit_out);
            if (ifc.done_out) done_cnt++;
            prev_stall = ifc.bit_valid && !r;
            prev_bit   = ifc.bit_out;
        end
    end

    task automatic drive(input sym_t s);
        ifc.lower_bound_in = s.lo;
        ifc.upper_bound_in = s.up;
        ifc.range_in       = s.tot;
        ifc.valid_in       = 1'b1;
    endtask

    task automatic send_burst(input symq_t q);
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            drive(q[i]);
        end
        @(negedge clk);
        ifc.valid_in = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); ifc.flush_in = 1'b1;
        @(negedge clk); ifc.flush_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        int waited = 0;
        while (done_cnt == start && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, done_cnt - start, 1);
    endtask

    task automatic compare_bits(input string name, input bitq_t exp);
        int first_bad = -1;
        for (int i = 0; i < got_bits.size() && i < exp.size(); i++)
            if (got_bits[i] != exp[i] && first_bad < 0) first_bad = i;
        check({name, "_bit_count"}, got_bits.size(), exp.size());
        check({name, "_first_bad_bit"}, first_bad, -1);
    endtask

    task automatic run_stream(input string name, input symq_t q);
        got_bits.delete();
        send_burst(q);
        pulse_flush();
        wait_done(name);
        compare_bits(name, model(q));
        check({name, "_idle_after"}, ifc.busy_out, 0);
    endtask

    initial begin
        vec_t  vt[8];
        symq_t gold, q, q17;
        bitq_t exp;

        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[8];
        symq_t gold, q, q17;
        bitq_t exp;

        vt[0] = '{16'd0, 16'd1, 16'd2, 3, 8'b0000_0001, 1'b0};
        vt[1] = '{16'd1, 16'd2, 16'd2, 3, 8'b0000_0101, 1'b0};
        vt[2] = '{16'd1, 16'd3, 16'd4, 3, 8'b0000_0011, 1'b0};
        vt[3] = '{16'd3, 16'd3, 16'd8, 2, 8'b0000_0001, 1'b1};
        vt[4] = '{16'd0, 16'd4, 16'd4, 2, 8'b0000_0001, 1'b0};
        vt[5] = '{16'd2, 16'd5, 16'd4, 2, 8'b0000_0001, 1'b1};
        vt[6] = '{16'd0, 16'd1, 16'd0, 2, 8'b0000_0001, 1'b1};
        vt[7] = '{16'd3, 16'd4, 16'd4, 4, 8'b0000_1101, 1'b0};

        ifc.lower_bound_in = '0;
        ifc.upper_bound_in = '0;
        ifc.range_in       = '0;
        ifc.valid_in       = 1'b0;
        ifc.flush_in       = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ifc.bit_out, ifc.bit_valid, ifc.done_out, ifc.busy_out,
                                ifc.overflow_out, ifc.error_out}, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single-triple vectors followed by flush.
        for (int i = 0; i < 8; i++) begin
            sym_t s;
            s.lo = vt[i].lo; s.up = vt[i].up; s.tot = vt[i].tot;
            got_bits.delete();
            exp.delete();
            for (int k = 0; k < vt[i].nbits; k++) exp.push_back(vt[i].bits[vt[i].nbits - 1 - k]);
            q.delete();
            q.push_back(s);
            send_burst(q);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d_error", i), ifc.error_out, vt[i].err);
            pulse_flush();
            wait_done($sformatf("vec%0d", i));
            compare_bits($sformatf("vec%0d", i), exp);
            check($sformatf("vec%0d_sticky_cleared", i), ifc.error_out, 0);
        end

        // Golden adaptive-model burst with latency measurement.
        gold = tree_model("aaaaabbbbbaaaaa");
        rand_ready = 1'b0;
        got_bits.delete();
        first_valid_cyc = -1;
        send_burst(gold);
        check("golden_no_overflow", ifc.overflow_out, 0);
        pulse_flush();
        wait_done("golden");
        check("golden_first_bit_latency", first_valid_cyc - start_cyc, 37);
        compare_bits("golden", model(gold));

        // Same stream under random backpressure.
        rand_ready = 1'b1;
        run_stream("golden_bp", gold);
        rand_ready = 1'b0;

        // 20 back-to-back writes: one popped, 16 stored, 3 dropped.
        q = tree_model("abaabbbabaababbaabab");
        got_bits.delete();
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 17) check("overflow_after_17_writes", ifc.overflow_out, 0);
            if (i == 18) check("overflow_after_18_writes", ifc.overflow_out, 1);
            drive(q[i]);
        end
        @(negedge clk);
        ifc.valid_in = 1'b0;
        pulse_flush();
        wait_done("overflow");
        q17 = q[0:16];
        compare_bits("overflow_17_coded", model(q17));

        // Reset while the divider is running, then a clean stream.
        q.delete();
        q.push_back(gold[0]);
        send_burst(q);
        repeat (8) @(posedge clk);
        #1;
        check("busy_before_reset", ifc.busy_out, 1);
        @(negedge clk) rst = 1'b0;
        #1;
        check("outputs_in_reset", {ifc.bit_out, ifc.bit_valid, ifc.done_out, ifc.busy_out,
                                   ifc.overflow_out, ifc.error_out}, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        run_stream("after_reset", gold);

        // Randomized streams, some illegal triples, random backpressure.
        for (int it = 0; it < 6; it++) begin
            int n;
            q.delete();
            n = int'($urandom_range(1, 15));
            rand_ready = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < n; k++) q.push_back(rand_sym());
            run_stream($sformatf("rand%0d", it), q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
